// File: rtl/mmio_pkg.sv
// Register map, STATUS and CTRL bit positions shared by mmio_port and its sub-blocks.
package mmio_pkg;

    localparam logic [1:0] OffTxData = 2'd0;
    localparam logic [1:0] OffStatus = 2'd1;
    localparam logic [1:0] OffRxData = 2'd2;
    localparam logic [1:0] OffCtrl   = 2'd3;

    localparam int unsigned StatTxFull  = 0;
    localparam int unsigned StatTxEmpty = 1;
    localparam int unsigned StatRxFull  = 2;
    localparam int unsigned StatTxOvf   = 3;

    localparam int unsigned CtrlClrOvf = 0;
    localparam int unsigned CtrlFlush  = 1;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with push/pop/flush; flush overrides both push and pop.
// Depth must be a power of two so the pointers wrap naturally.
module sync_fifo #(
    parameter int unsigned Width = 8,
    parameter int unsigned Depth = 4,
    localparam int unsigned PtrW = $clog2(Depth),
    localparam int unsigned CntW = PtrW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [Width-1:0] wdata,
    output logic [Width-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CntW-1:0]  count
);

    logic [Width-1:0] mem [Depth];
    logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign full  = (cnt_q == CntW'(Depth));
    assign empty = (cnt_q == '0);
    assign count = cnt_q;

    assign do_pop  = pop && !empty && !flush;
    // A pop on the same edge frees a slot, so a full FIFO may still accept.
    assign do_push = push && (!full || do_pop) && !flush;

    assign rdata = empty ? '0 : mem[rd_ptr_q];

    always_comb begin
        cnt_d = cnt_q;
        if (flush) begin
            cnt_d = '0;
        end else if (do_push && !do_pop) begin
            cnt_d = cnt_q + CntW'(1);
        end else if (!do_push && do_pop) begin
            cnt_d = cnt_q - CntW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            cnt_q <= cnt_d;
            if (flush) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
            end else begin
                if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
                if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/mmio_port.sv
// CPU-mapped byte port: TX FIFO, sticky overflow flag, and an optional RX holding register
// enabled by defining MMIO_PORT_RX_EN.
module mmio_port
    import mmio_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter logic [12:0] BASE_ADDR  = 13'h1800
) (
    input  logic        sys_clk,
    input  logic        rst,
    input  logic [12:0] addr,
    input  logic        rd,
    input  logic        wr,
    input  logic        ena,
    inout  logic [7:0]  data,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data_in,
    input  logic        rx_valid_in,
    output logic        rx_ready
);

    localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;

    logic            selected;
    logic [1:0]      off;
    logic            wr_sel, wr_q, commit;
    logic            rd_act;
    logic            tx_wr, tx_pop, tx_flush, tx_full, tx_empty;
    logic            tx_ovf_q, tx_ovf_d;
    logic            rx_full;
    logic [7:0]      rx_rdata;
    logic [7:0]      status, rdata;
    logic [CntW-1:0] unused_tx_count;

    assign selected = ena && (addr[12:2] == BASE_ADDR[12:2]);
    assign off      = addr[1:0];

    // Writes act once per strobe, on the edge where the selected write first appears.
    assign wr_sel = selected && wr;
    assign commit = wr_sel && !wr_q;
    assign rd_act = selected && rd && !wr;

    assign tx_wr    = commit && (off == OffTxData);
    assign tx_flush = commit && (off == OffCtrl) && data[CtrlFlush];
    assign tx_pop   = tx_valid && tx_ready;
    assign tx_valid = !tx_empty;

    sync_fifo #(
        .Width (8),
        .Depth (FIFO_DEPTH)
    ) u_tx_fifo (
        .clk   (sys_clk),
        .rst   (rst),
        .push  (tx_wr),
        .pop   (tx_pop),
        .flush (tx_flush),
        .wdata (data),
        .rdata (tx_data),
        .full  (tx_full),
        .empty (tx_empty),
        .count (unused_tx_count)
    );

    always_comb begin
        tx_ovf_d = tx_ovf_q;
        if (commit && (off == OffCtrl) && data[CtrlClrOvf]) begin
            tx_ovf_d = 1'b0;
        end else if (tx_wr && tx_full && !tx_pop) begin
            tx_ovf_d = 1'b1;
        end
    end

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            wr_q     <= 1'b0;
            tx_ovf_q <= 1'b0;
        end else begin
            wr_q     <= wr_sel;
            tx_ovf_q <= tx_ovf_d;
        end
    end

`ifdef MMIO_PORT_RX_EN
    logic       rd_q;
    logic [1:0] rd_off_q;
    logic       rx_full_q, rx_full_d;
    logic [7:0] rx_data_q;
    logic       rx_cap, rx_consume;

    assign rx_ready   = !rx_full_q;
    assign rx_cap     = rx_valid_in && rx_ready;
    // Consume when a read of RXDATA ends, so the byte stays on the bus for the whole read.
    assign rx_consume = rd_q && !rd_act && (rd_off_q == OffRxData);

    always_comb begin
        rx_full_d = rx_full_q;
        if (rx_consume) rx_full_d = 1'b0;
        if (rx_cap)     rx_full_d = 1'b1;
    end

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            rd_q      <= 1'b0;
            rd_off_q  <= 2'd0;
            rx_full_q <= 1'b0;
            rx_data_q <= 8'h00;
        end else begin
            rd_q      <= rd_act;
            rx_full_q <= rx_full_d;
            if (rd_act) rd_off_q  <= off;
            if (rx_cap) rx_data_q <= rx_data_in;
        end
    end

    assign rx_full  = rx_full_q;
    assign rx_rdata = rx_data_q;
`else
    logic unused_rx;

    assign unused_rx = ^{rx_data_in, rx_valid_in};
    assign rx_ready  = 1'b0;
    assign rx_full   = 1'b0;
    assign rx_rdata  = 8'h00;
`endif

    always_comb begin
        status              = 8'h00;
        status[StatTxFull]  = tx_full;
        status[StatTxEmpty] = tx_empty;
        status[StatRxFull]  = rx_full;
        status[StatTxOvf]   = tx_ovf_q;
    end

    always_comb begin
        rdata = 8'h00;
        case (off)
            OffStatus: rdata = status;
            OffRxData: rdata = rx_rdata;
            default:   rdata = 8'h00;
        endcase
    end

    assign data = rd_act ? rdata : 8'hzz;

endmodule

// File: tb/tb_mmio_port.sv
// Directed bench for mmio_port: transaction-level queue model checked every cycle, plus
// literal expectations for the register-visible scenarios. RX checks follow MMIO_PORT_RX_EN.
module tb_mmio_port;

    localparam int unsigned DEPTH = 4;
    localparam logic [12:0] BASE  = 13'h1800;

    logic        sys_clk, rst;
    logic [12:0] addr;
    logic        rd, wr, ena;
    wire  [7:0]  data;
    logic [7:0]  drv;
    logic        drv_en;
    logic [7:0]  tx_data;
    logic        tx_valid, tx_ready;
    logic [7:0]  rx_data_in;
    logic        rx_valid_in, rx_ready;

    assign data = drv_en ? drv : 8'hzz;

    mmio_port #(
        .FIFO_DEPTH (DEPTH),
        .BASE_ADDR  (BASE)
    ) dut (
        .sys_clk     (sys_clk),
        .rst         (rst),
        .addr        (addr),
        .rd          (rd),
        .wr          (wr),
        .ena         (ena),
        .data        (data),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .rx_data_in  (rx_data_in),
        .rx_valid_in (rx_valid_in),
        .rx_ready    (rx_ready)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [7:0] txq[$];
    bit         m_ovf, m_rx_full;
    logic [7:0] m_rx_byte;
    bit         m_wr_pend, m_rd_fall, m_pop, m_cap;
    logic [1:0] m_off, m_rd_off;
    logic [7:0] m_val;

    always @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            txq.delete();
            m_ovf     = 0;
            m_rx_full = 0;
            m_wr_pend = 0;
            m_rd_fall = 0;
        end else begin
            m_pop = tx_ready && (txq.size() != 0);
`ifdef MMIO_PORT_RX_EN
            m_cap = rx_valid_in && !m_rx_full;
`else
            m_cap = 0;
`endif
            if (m_pop) void'(txq.pop_front());
            if (m_wr_pend) begin
                m_wr_pend = 0;
                if (m_off == 2'd0) begin
                    if (txq.size() < DEPTH) txq.push_back(m_val);
                    else m_ovf = 1;
                end else if (m_off == 2'd3) begin
                    if (m_val[0]) m_ovf = 0;
                    if (m_val[1]) txq.delete();
                end
            end
            if (m_rd_fall) begin
                m_rd_fall = 0;
                if (m_rd_off == 2'd2) m_rx_full = 0;
            end
            if (m_cap) begin
                m_rx_full = 1;
                m_rx_byte = rx_data_in;
            end
        end
    end

    logic [7:0] exp_head;
    logic       exp_rx_ready;

    always @(negedge sys_clk) begin
        exp_head = 8'h00;
        if (txq.size() != 0) exp_head = txq[0];
`ifdef MMIO_PORT_RX_EN
        exp_rx_ready = !m_rx_full;
`else
        exp_rx_ready = 1'b0;
`endif
        check("cyc_tx_valid", {7'd0, tx_valid}, {7'd0, txq.size() != 0});
        check("cyc_tx_data", tx_data, exp_head);
        check("cyc_rx_ready", {7'd0, rx_ready}, {7'd0, exp_rx_ready});
    end

    // ---------------- bus tasks ----------------
    task automatic bus_write(input logic [12:0] a, input logic [7:0] v, input int hold,
                             input bit en);
        @(posedge sys_clk); #1;
        addr = a; ena = en; wr = 1'b1; drv = v; drv_en = 1'b1;
        if (en && a[12:2] == BASE[12:2]) begin
            m_wr_pend = 1; m_off = a[1:0]; m_val = v;
        end
        repeat (hold) @(posedge sys_clk);
        #1;
        wr = 1'b0; ena = 1'b0; drv_en = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] o, input int hold, output logic [7:0] first,
                            output logic [7:0] last);
        @(posedge sys_clk); #1;
        addr = BASE | {11'd0, o}; ena = 1'b1; rd = 1'b1;
        #1 first = data;
        repeat (hold) @(posedge sys_clk);
        #1 last = data;
        rd = 1'b0; ena = 1'b0;
        m_rd_fall = 1; m_rd_off = o;
    endtask

    task automatic read_status(input string name, input logic [7:0] exp);
        logic [7:0] f, l;
        bus_read(2'd1, 1, f, l);
        check(name, f, exp);
    endtask

    task automatic rx_pulse(input logic [7:0] v);
        @(posedge sys_clk); #1;
        rx_data_in = v; rx_valid_in = 1'b1;
        @(posedge sys_clk); #1;
        rx_valid_in = 1'b0;
    endtask

    localparam logic [12:0] A_TX   = BASE | 13'd0;
    localparam logic [12:0] A_CTRL = BASE | 13'd3;

    initial begin
        logic [7:0] v1, v2;
        rst = 1'b1; addr = '0; rd = 0; wr = 0; ena = 0; drv = 0; drv_en = 0;
        tx_ready = 0; rx_data_in = 0; rx_valid_in = 0;
        repeat (3) @(posedge sys_clk);
        #1 rst = 1'b0;

        check("rst_tx_valid", {7'd0, tx_valid}, 8'h00);
        check("rst_tx_data", tx_data, 8'h00);
`ifdef MMIO_PORT_RX_EN
        check("rst_rx_ready", {7'd0, rx_ready}, 8'h01);
`else
        check("rst_rx_ready", {7'd0, rx_ready}, 8'h00);
`endif
        read_status("rst_status", 8'h02);

        // Two bytes queued, then drained on consecutive edges.
        bus_write(A_TX, 8'hA5, 1, 1);
        bus_write(A_TX, 8'h3C, 1, 1);
        read_status("two_status", 8'h00);
        @(posedge sys_clk); #1 tx_ready = 1;
        check("drain0", tx_data, 8'hA5);
        @(posedge sys_clk); #1 check("drain1", tx_data, 8'h3C);
        @(posedge sys_clk); #1 check("drain_empty", {7'd0, tx_valid}, 8'h00);
        tx_ready = 0;
        read_status("two_after", 8'h02);

        // Overflow: fifth byte dropped, sticky flag until CTRL clears it.
        for (int i = 0; i < 5; i++) bus_write(A_TX, 8'h11 + 8'(i), 1, 1);
        read_status("ovf_status", 8'h09);
        @(posedge sys_clk); #1 tx_ready = 1;
        for (int i = 0; i < 4; i++) begin
            check("ovf_drain", tx_data, 8'h11 + 8'(i));
            @(posedge sys_clk); #1;
        end
        check("ovf_drain_end", {7'd0, tx_valid}, 8'h00);
        tx_ready = 0;
        read_status("ovf_sticky", 8'h0A);
        bus_write(A_CTRL, 8'h01, 1, 1);
        read_status("ovf_cleared", 8'h02);

        // Held write strobe pushes once.
        bus_write(A_TX, 8'h77, 3, 1);
        read_status("hold_status", 8'h00);
        @(posedge sys_clk); #1 tx_ready = 1;
        check("hold_head", tx_data, 8'h77);
        @(posedge sys_clk); #1 check("hold_single", {7'd0, tx_valid}, 8'h00);
        tx_ready = 0;

        // Unselected writes are ignored.
        bus_write(A_TX, 8'h55, 1, 0);
        bus_write(13'h1804, 8'h66, 1, 1);
        bus_write(13'h0800, 8'h67, 1, 1);
        read_status("unsel_status", 8'h02);

        // Write-only registers read as zero.
        bus_read(2'd0, 1, v1, v2);
        check("rd_txdata", v1, 8'h00);
        bus_read(2'd3, 1, v1, v2);
        check("rd_ctrl", v1, 8'h00);

        // Flush empties the FIFO.
        for (int i = 0; i < 3; i++) bus_write(A_TX, 8'h30 + 8'(i), 1, 1);
        bus_write(A_CTRL, 8'h02, 1, 1);
        check("flush_valid", {7'd0, tx_valid}, 8'h00);
        read_status("flush_status", 8'h02);

        // Full FIFO with pop and push on the same edge: no overflow, stays full.
        for (int i = 0; i < 4; i++) bus_write(A_TX, 8'h21 + 8'(i), 1, 1);
        read_status("full_status", 8'h01);
        @(posedge sys_clk); #1;
        addr = A_TX; ena = 1; wr = 1; drv = 8'h99; drv_en = 1; tx_ready = 1;
        m_wr_pend = 1; m_off = 2'd0; m_val = 8'h99;
        @(posedge sys_clk); #1;
        wr = 0; ena = 0; drv_en = 0; tx_ready = 0;
        read_status("pushpop_status", 8'h01);
        @(posedge sys_clk); #1 tx_ready = 1;
        check("pp_d0", tx_data, 8'h22);
        @(posedge sys_clk); #1 check("pp_d1", tx_data, 8'h23);
        @(posedge sys_clk); #1 check("pp_d2", tx_data, 8'h24);
        @(posedge sys_clk); #1 check("pp_d3", tx_data, 8'h99);
        @(posedge sys_clk); #1 tx_ready = 0;

        // Reset mid-transfer discards the queue; next write is a fresh edge.
        for (int i = 0; i < 3; i++) bus_write(A_TX, 8'h40 + 8'(i), 1, 1);
        @(posedge sys_clk); #1 rst = 1;
        #1 check("rst_mid_valid", {7'd0, tx_valid}, 8'h00);
        @(posedge sys_clk); #1 rst = 0;
        read_status("rst_mid_status", 8'h02);
        bus_write(A_TX, 8'hBB, 1, 1);
        read_status("post_rst_push", 8'h00);
        bus_write(A_CTRL, 8'h02, 1, 1);

`ifdef MMIO_PORT_RX_EN
        rx_pulse(8'h5A);
        check("rx_ready_low", {7'd0, rx_ready}, 8'h00);
        read_status("rx_status", 8'h06);
        rx_pulse(8'h77);
        bus_read(2'd2, 2, v1, v2);
        check("rx_read_first", v1, 8'h5A);
        check("rx_read_last", v2, 8'h5A);
        @(posedge sys_clk); #1 check("rx_consumed", {7'd0, rx_ready}, 8'h01);
        read_status("rx_status_after", 8'h02);
        rx_pulse(8'hC3);
        bus_read(2'd2, 1, v1, v2);
        check("rx_second", v1, 8'hC3);
`else
        rx_pulse(8'h5A);
        check("rx_ready_off", {7'd0, rx_ready}, 8'h00);
        read_status("rx_status_off", 8'h02);
        bus_read(2'd2, 1, v1, v2);
        check("rx_read_off", v1, 8'h00);
`endif
        repeat (3) @(posedge sys_clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mmio_port.md
MMIO_PORT -- requirements
Module: mmio_port

Interface
REQ-001 Parameter FIFO_DEPTH, default 4: TX FIFO entry count; power of two, 2..16.
REQ-002 Parameter BASE_ADDR, default 13'h1800: CPU address of register 0; bits [1:0] = 0.
REQ-003 sys_clk  in  1  sole clock; all state updates on rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 addr  in  13  CPU bus address.
REQ-006 rd  in  1  CPU read strobe, level, held for one or more cycles.
REQ-007 wr  in  1  CPU write strobe, level, held for one or more cycles.
REQ-008 ena  in  1  chip select from the address decoder.
REQ-009 data  inout  8  CPU data bus; driven only during a selected read, otherwise high-Z.
REQ-010 tx_data  out  8  head of TX FIFO.
REQ-011 tx_valid  out  1  TX FIFO non-empty.
REQ-012 tx_ready  in  1  consumer accepts tx_data when tx_valid && tx_ready.
REQ-013 rx_data_in  in  8  inbound byte.
REQ-014 rx_valid_in  in  1  inbound byte valid.
REQ-015 rx_ready  out  1  RX holding register empty.

Function
REQ-016 Selected = ena && addr[12:2] == BASE_ADDR[12:2]; off = addr[1:0].
REQ-017 Register map: 0 TXDATA (W), 1 STATUS (R), 2 RXDATA (R), 3 CTRL (W); reads of write-only registers return 8'h00.
REQ-018 STATUS = {4'b0, tx_ovf, rx_full, tx_empty, tx_full}.
REQ-019 Read data is driven combinationally while selected && rd && !wr.
REQ-020 A write commits exactly once, on the first sys_clk edge where selected && wr is high and was low at the previous edge (registered wr edge detect).
REQ-021 TXDATA write when FIFO not full: push data; when full: discard byte, set sticky tx_ovf.
REQ-022 CTRL write with data[0]=1 clears tx_ovf; data[1]=1 flushes TX FIFO; both same cycle as commit.
REQ-023 TX pop on every edge with tx_valid && tx_ready; push and pop on the same edge when full or non-empty both succeed, count unchanged.
REQ-024 Flush coincident with push: flush wins, FIFO ends empty, no overflow.
REQ-025 Pointers wrap modulo FIFO_DEPTH; count width clog2(FIFO_DEPTH)+1.
REQ-026 RX holding register captures rx_data_in on an edge with rx_valid_in && rx_ready; rx_full set.
REQ-027 RXDATA read consumes on the falling edge of selected && rd (registered rd edge detect): rx_full cleared next edge; the value stays driven for the full read.
REQ-028 Capture and consume on the same edge: consume applies to old byte, new byte captured, rx_full stays 1.
REQ-029 rd && wr both high while selected: write commits, no read drive, no RX consume.

Reset
REQ-030 On rst: FIFO empty, pointers 0, tx_valid=0, tx_data=8'h00, tx_ovf=0, rx_full=0, rx_ready=1, edge-detect registers 0, data high-Z.
REQ-031 Reset asserted mid-transfer discards all FIFO and RX contents; the first strobe after release is treated as a fresh edge.

Configuration
REQ-032 Macro MMIO_PORT_RX_EN: defined -> RX path per REQ-026..028.
REQ-033 Undefined -> no RX register; rx_ready=0, RXDATA reads 8'h00, STATUS[2]=0.

Structure
REQ-034 Package mmio_pkg holds register offsets, STATUS bit indices, CTRL bit indices.
REQ-035 TX FIFO is a sub-module sync_fifo (parameterised width/depth, push/pop/flush, full/empty/count).

Verification
REQ-036 Write 8'hA5, 8'h3C to TXDATA with tx_ready=0 -> STATUS=8'h00 (not empty, not full); raise tx_ready -> A5 then 3C on consecutive edges, then STATUS=8'h02.
REQ-037 Write 5 bytes to TXDATA with FIFO_DEPTH=4, tx_ready=0 -> STATUS=8'h09; 5th byte absent from drain; CTRL write 8'h01 -> STATUS bit3 cleared.
REQ-038 wr held 3 cycles on TXDATA -> exactly one push (count 1).
REQ-039 MMIO_PORT_RX_EN: rx_data_in=8'h5A pulsed -> rx_ready=0, STATUS bit2=1; read RXDATA -> data=8'h5A, after rd falls rx_ready=1.
REQ-040 Full FIFO with tx_ready=1 and simultaneous TXDATA write -> count stays 4, no tx_ovf.
REQ-041 rst asserted with 3 entries queued -> tx_valid=0 immediately, STATUS=8'h02 after release.
